pc_ras_unit: RTL and testbench

Parametrised program-counter unit for the multi-cycle datapath.
- Replaces the plain PC register.
- Adds sequential increment, branch/jump load, and call/return through an internal return-address stack (RAS).
- Updates only in the fetch/writeback cycles where control asserts PCWrite.
- Feeds instruction-memory address and the ALU PC operand.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_ras_stack.sv | 56 +++++
 rtl/pc_ras_unit.sv | 143 ++++++++++++++
 tb/tb_pc_ras_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the PC / return-address-stack unit.
// Provides the default PC width and the 2-bit PC update mode type.
package pc_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_LOAD = 2'b01,
        PC_CALL = 2'b10,
        PC_RET  = 2'b11
    } pc_mode_e;

endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular LIFO of return addresses.
// Ports: CLK, RST (async, active-high), push, pop, din -> top (0 when
// empty), count, full, empty. Push while full overwrites the oldest entry.
module pc_ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       top,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;

    // ptr is the next free slot; the top lives one below it.
    assign top_idx = ptr - PW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            // Full push wraps onto the oldest entry; count saturates.
            if (!full) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= ptr - PW'(1);
            count <= count - (PW+1)'(1);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
    assign top   = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: PC register with SEQ/LOAD/CALL/RET update and internal RAS.
// Ports: CLK, RST, input_PC_{PCWrite,mode,newPC,errClr} -> output_PC,
// output_PC_{retAddr,rasCount,rasFull,rasEmpty,ovf,unf}.
// Macro PC_RAS_TRAP_EN: stack faults jump to TRAP_VECTOR instead of
// overwriting (CALL) or falling back to newPC (RET).
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_W,
    parameter int               RAS_DEPTH    = 8,
    parameter int               INC          = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(16'h0010)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       input_PC_PCWrite,
    input  logic [1:0]                 input_PC_mode,
    input  logic [WIDTH-1:0]           input_PC_newPC,
    input  logic                       input_PC_errClr,
    output logic [WIDTH-1:0]           output_PC,
    output logic [WIDTH-1:0]           output_PC_retAddr,
    output logic [$clog2(RAS_DEPTH):0] output_PC_rasCount,
    output logic                       output_PC_rasFull,
    output logic                       output_PC_rasEmpty,
    output logic                       output_PC_ovf,
    output logic                       output_PC_unf
);

    pc_mode_e         mode;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] link;
    logic [WIDTH-1:0] ret_addr;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             ovf_hit;
    logic             unf_hit;
    logic             ovf_q;
    logic             unf_q;

    assign mode = pc_mode_e'(input_PC_mode);
    assign link = pc_q + WIDTH'(INC);

`ifndef PC_RAS_TRAP_EN
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
`endif

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        if (input_PC_PCWrite) begin
            unique case (mode)
                PC_SEQ: begin
                    pc_d = link;
                end
                PC_LOAD: begin
                    pc_d = input_PC_newPC;
                end
                PC_CALL: begin
                    ovf_hit = full;
`ifdef PC_RAS_TRAP_EN
                    if (full) begin
                        pc_d = TRAP_VECTOR;
                    end else begin
                        push = 1'b1;
                        pc_d = input_PC_newPC;
                    end
`else
                    push = 1'b1;
                    pc_d = input_PC_newPC;
`endif
                end
                PC_RET: begin
                    unf_hit = empty;
                    if (empty) begin
`ifdef PC_RAS_TRAP_EN
                        pc_d = TRAP_VECTOR;
`else
                        pc_d = input_PC_newPC;
`endif
                    end else begin
                        pop  = 1'b1;
                        pc_d = ret_addr;
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            // A fault in the clearing cycle keeps the flag set.
            if (ovf_hit) begin
                ovf_q <= 1'b1;
            end else if (input_PC_errClr) begin
                ovf_q <= 1'b0;
            end
            if (unf_hit) begin
                unf_q <= 1'b1;
            end else if (input_PC_errClr) begin
                unf_q <= 1'b0;
            end
        end
    end

    pc_ras_stack #(
        .WIDTH(WIDTH),
        .DEPTH(RAS_DEPTH)
    ) u_stack (
        .CLK  (CLK),
        .RST  (RST),
        .push (push),
        .pop  (pop),
        .din  (link),
        .top  (ret_addr),
        .count(output_PC_rasCount),
        .full (full),
        .empty(empty)
    );

    assign output_PC          = pc_q;
    assign output_PC_retAddr  = ret_addr;
    assign output_PC_rasFull  = full;
    assign output_PC_rasEmpty = empty;
    assign output_PC_ovf      = ovf_q;
    assign output_PC_unf      = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed plus random checks of pc_ras_unit against a
// queue-based return-address model.
module tb_pc_ras_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pcw = 1'b0;
    logic [1:0]  md  = 2'b00;
    logic [15:0] np  = 16'h0000;
    logic        clr = 1'b0;
    logic [15:0] pc;
    logic [15:0] ra;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mpc = 16'h0000;
    logic [15:0] mq[$];
    logic        movf = 1'b0;
    logic        munf = 1'b0;

    pc_ras_unit #(
        .WIDTH(16),
        .RAS_DEPTH(8),
        .INC(2),
        .RESET_VECTOR(16'h0000),
        .TRAP_VECTOR(16'h0010)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .input_PC_PCWrite  (pcw),
        .input_PC_mode     (md),
        .input_PC_newPC    (np),
        .input_PC_errClr   (clr),
        .output_PC         (pc),
        .output_PC_retAddr (ra),
        .output_PC_rasCount(cnt),
        .output_PC_rasFull (full),
        .output_PC_rasEmpty(empty),
        .output_PC_ovf     (ovf),
        .output_PC_unf     (unf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [15:0] eta;
        eta = (mq.size() == 0) ? 16'h0000 : mq[$];
        chk({tag, ".pc"}, 32'(pc), 32'(mpc));
        chk({tag, ".ra"}, 32'(ra), 32'(eta));
        chk({tag, ".cnt"}, 32'(cnt), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".ovf"}, 32'(ovf), 32'(movf));
        chk({tag, ".unf"}, 32'(unf), 32'(munf));
    endtask

    task automatic model(input bit w, input bit [1:0] m,
                         input logic [15:0] n, input bit c);
        bit of = 0;
        bit uf = 0;
        if (w) begin
            case (m)
                2'd0: mpc = mpc + 16'd2;
                2'd1: mpc = n;
                2'd2: begin
                    if (mq.size() == 8) begin
                        of = 1;
`ifdef PC_RAS_TRAP_EN
                        mpc = 16'h0010;
`else
                        void'(mq.pop_front());
                        mq.push_back(mpc + 16'd2);
                        mpc = n;
`endif
                    end else begin
                        mq.push_back(mpc + 16'd2);
                        mpc = n;
                    end
                end
                default: begin
                    if (mq.size() == 0) begin
                        uf = 1;
`ifdef PC_RAS_TRAP_EN
                        mpc = 16'h0010;
`else
                        mpc = n;
`endif
                    end else begin
                        mpc = mq.pop_back();
                    end
                end
            endcase
        end
        movf = of | (movf & ~c);
        munf = uf | (munf & ~c);
    endtask

    task automatic step(input string tag, input bit w, input bit [1:0] m,
                        input logic [15:0] n, input bit c);
        pcw = w;
        md  = m;
        np  = n;
        clr = c;
        @(posedge CLK);
        #1;
        model(w, m, n, c);
        chk_model(tag);
    endtask

    initial begin
        // Reset state
        @(posedge CLK);
        #1;
        chk_model("reset");
        chk("reset.pc0", 32'(pc), 32'h0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Sequential increment and hold
        step("seq1", 1, 2'd0, 16'h0000, 0);
        chk("seq1.const", 32'(pc), 32'h0002);
        step("seq2", 1, 2'd0, 16'h0000, 0);
        step("seq3", 1, 2'd0, 16'h0000, 0);
        chk("seq3.const", 32'(pc), 32'h0006);
        step("hold", 0, 2'd2, 16'h1234, 0);
        chk("hold.const", 32'(pc), 32'h0006);

        // Wrap at the top of the address space
        step("wrap.ld", 1, 2'd1, 16'hFFFE, 0);
        step("wrap.seq", 1, 2'd0, 16'h0000, 0);
        chk("wrap.const", 32'(pc), 32'h0000);

        // Nested call / return
        step("nest.ld", 1, 2'd1, 16'h0100, 0);
        step("nest.c1", 1, 2'd2, 16'h0200, 0);
        step("nest.c2", 1, 2'd2, 16'h0300, 0);
        chk("nest.ra", 32'(ra), 32'h0202);
        chk("nest.cnt", 32'(cnt), 32'd2);
        step("nest.r1", 1, 2'd3, 16'h0000, 0);
        chk("nest.r1pc", 32'(pc), 32'h0202);
        step("nest.r2", 1, 2'd3, 16'h0000, 0);
        chk("nest.r2pc", 32'(pc), 32'h0102);
        chk("nest.empty", 32'(empty), 32'd1);

        // Overflow with 9 calls from 1000..1010
        step("ovf.ld", 1, 2'd1, 16'h1000, 0);
        for (int i = 0; i < 9; i++) begin
            step("ovf.call", 1, 2'd2, mpc + 16'd2, 0);
        end
        chk("ovf.cnt", 32'(cnt), 32'd8);
        chk("ovf.flag", 32'(ovf), 32'd1);
`ifdef PC_RAS_TRAP_EN
        chk("ovf.trap", 32'(pc), 32'h0010);
`else
        for (int i = 0; i < 8; i++) begin
            step("ovf.ret", 1, 2'd3, 16'h0000, 0);
            chk("ovf.retpc", 32'(pc), 32'(16'h1012 - 16'(2 * i)));
        end
        step("unf.ret", 1, 2'd3, 16'hABCC, 0);
        chk("unf.pc", 32'(pc), 32'hABCC);
        chk("unf.flag", 32'(unf), 32'd1);
`endif

        // errClr priority
        step("clr.nofault", 1, 2'd0, 16'h0000, 1);
        chk("clr.ovf", 32'(ovf), 32'd0);
        while (mq.size() != 0) begin
            step("clr.drain", 1, 2'd3, 16'h0000, 0);
        end
        step("clr.fault", 1, 2'd3, 16'h2220, 1);
        chk("clr.unf", 32'(unf), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 16'($urandom) & 16'hFFFE, $urandom_range(0, 7) == 0);
        end

        // Make sure the stack holds something before the async reset
        step("ar.c1", 1, 2'd2, 16'h0400, 0);
        step("ar.c2", 1, 2'd2, 16'h0500, 0);

        // Async reset between edges, during a CALL
        pcw = 1'b1;
        md  = 2'd2;
        np  = 16'h4444;
        clr = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        mpc  = 16'h0000;
        mq.delete();
        movf = 1'b0;
        munf = 1'b0;
        chk_model("async");
        @(posedge CLK);
        #1;
        chk_model("async.hold");
        RST = 1'b0;
        step("post.seq", 1, 2'd0, 16'h0000, 0);
        step("post.call", 1, 2'd2, 16'h0600, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
